dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: width, 32, data and memory address bus width in bits.
REQ-002 Parameter: ADDR_W, 8, requester address width in bits; ADDR_W <= width.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 a_req  input  1  port A (core) request; held until a_ack.
REQ-006 a_we  input  1  port A write (1) / read (0).
REQ-007 a_addr  input  ADDR_W  port A word address.
REQ-008 a_wdata  input  width  port A write data.
REQ-009 a_ack  output  1  port A one-cycle completion pulse.
REQ-010 a_rdata  output  width  port A read data, valid while a_ack=1.
REQ-011 b_req, b_we, b_addr, b_wdata, b_ack, b_rdata: same directions, widths and meanings as the port A signals, for port B (debug/DMA).
REQ-012 mem_we  output  1  data memory write enable.
REQ-013 mem_addr  output  width  data memory address.
REQ-014 mem_wdata  output  width  data memory write data.
REQ-015 mem_rdata  input  width  data memory combinational read data.

Function
REQ-016 The FSM SHALL have three states: IDLE, ACK_A, ACK_B.
REQ-017 In IDLE with no request, the block SHALL drive mem_we=0, mem_addr=0 and mem_wdata=0.
REQ-018 In IDLE with a request, the block SHALL select a winner, drive the winner's we/addr/wdata onto the mem_* outputs combinationally in the same cycle, and move to ACK_A or ACK_B.
REQ-019 mem_addr SHALL be the winner's address zero-extended from ADDR_W to width bits.
REQ-020 On the grant edge, the block SHALL capture mem_rdata into an internal rdata register, for both reads and writes.
REQ-021 In ACK_x, the block SHALL pulse x_ack=1 for exactly one cycle, drive mem_we=0, grant nothing, and return to IDLE.
REQ-022 Latency SHALL be 1 cycle from the grant cycle to ack; throughput SHALL be at most one access per 2 cycles.
REQ-023 a_rdata and b_rdata SHALL both present the rdata register; each is valid only while its own ack is high.
REQ-024 A request withdrawn before grant SHALL be ignored with no side effect.
REQ-025 A requester SHALL deassert req or present its next access in its ack cycle; the block does not sample req in ACK states.
REQ-026 A write followed by a read of the same address SHALL return the written data.
REQ-027 At most one of a_ack and b_ack SHALL be high in any cycle.
REQ-028 At most one grant SHALL be issued per IDLE cycle.

Reset
REQ-029 While rst_n=0, the block SHALL set state=IDLE, a_ack=0, b_ack=0, rdata register=0 and the priority pointer to A, with all mem_* outputs at 0.
REQ-030 Reset asserted in ACK_x SHALL drop the pending ack immediately; the aborted access SHALL NOT be acked after reset release.
REQ-031 The first request after reset release SHALL be serviceable in the first clock cycle following release.

Configuration
REQ-032 Macro DMEM_ARB_RR_EN defined: round-robin arbitration; on simultaneous requests the port not granted last wins; the pointer updates on each grant.
REQ-033 Macro DMEM_ARB_RR_EN undefined: fixed priority, A always beats B; no pointer state is implemented.

Verification
REQ-034 Reset, then a_req=1, a_we=1, a_addr=0x05, a_wdata=0xDEADBEEF -> mem_we=1 and mem_addr=0x00000005 in the grant cycle; a_ack=1 in the next cycle.
REQ-035 Then b_req=1, b_we=0, b_addr=0x05 -> b_ack pulse one cycle after grant with b_rdata=0xDEADBEEF; a_ack stays 0.
REQ-036 a_req and b_req held high for 8 cycles with DMEM_ARB_RR_EN defined -> acks alternate A,B,A,B, 4 total, one ack every 2 cycles.
REQ-037 Same stimulus with DMEM_ARB_RR_EN undefined -> 4 a_acks, 0 b_acks.
REQ-038 rst_n pulsed low during ACK_B -> b_ack=0 immediately, state returns to IDLE, no ack after release, next b request acked normally.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port (A = core, B = debug/DMA) arbiter in front of a single-port
// data memory with combinational read. Each access takes two cycles: a grant cycle
// in which the winner drives the memory, then an ack cycle.
// Configuration macro: DMEM_ARB_RR_EN
//   defined   -> round-robin between A and B on simultaneous requests
//   undefined -> fixed priority, A always beats B (default build)
module dmem_arbiter #(
    parameter int unsigned width  = 32,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [width-1:0]  a_wdata,
    output logic              a_ack,
    output logic [width-1:0]  a_rdata,

    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [width-1:0]  b_wdata,
    output logic              b_ack,
    output logic [width-1:0]  b_rdata,

    output logic              mem_we,
    output logic [width-1:0]  mem_addr,
    output logic [width-1:0]  mem_wdata,
    input  logic [width-1:0]  mem_rdata
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAckA = 2'd1,
        StAckB = 2'd2
    } state_e;

    state_e           state;
    logic [width-1:0] rdata_q;
    logic             grant_a;
    logic             grant_b;
    logic             idle_live;

    // Grants are only issued from IDLE and never while reset is asserted, so the
    // memory outputs are quiet during reset even if a requester is active.
    assign idle_live = rst_n && (state == StIdle);

`ifdef DMEM_ARB_RR_EN
    // Set when B should win the next tie, i.e. A was granted last.
    logic prio_b;

    // Round-robin winner selection: a tie goes to the port not granted last.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (idle_live) begin
            if (a_req && b_req) begin
                grant_a = !prio_b;
                grant_b = prio_b;
            end else begin
                grant_a = a_req;
                grant_b = b_req;
            end
        end
    end

    // Priority pointer flips toward the other port on every grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_b <= 1'b0;
        end else if (grant_a) begin
            prio_b <= 1'b1;
        end else if (grant_b) begin
            prio_b <= 1'b0;
        end
    end
`else
    // Fixed-priority winner selection: A always beats B.
    always_comb begin
        grant_a = idle_live && a_req;
        grant_b = idle_live && b_req && !a_req;
    end
`endif

    // Memory-side mux: the winner drives the memory in its grant cycle, zero otherwise.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant_a) begin
            mem_we    = a_we;
            mem_addr  = width'(a_addr);
            mem_wdata = a_wdata;
        end else if (grant_b) begin
            mem_we    = b_we;
            mem_addr  = width'(b_addr);
            mem_wdata = b_wdata;
        end
    end

    // Access FSM with registered acks; read data is captured on the grant edge.
    // Requests are not looked at in the ACK states, so a requester may present its
    // next access during its own ack cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= StIdle;
            a_ack   <= 1'b0;
            b_ack   <= 1'b0;
            rdata_q <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    a_ack <= 1'b0;
                    b_ack <= 1'b0;
                    if (grant_a) begin
                        state   <= StAckA;
                        a_ack   <= 1'b1;
                        rdata_q <= mem_rdata;
                    end else if (grant_b) begin
                        state   <= StAckB;
                        b_ack   <= 1'b1;
                        rdata_q <= mem_rdata;
                    end
                end
                StAckA: begin
                    state <= StIdle;
                    a_ack <= 1'b0;
                end
                StAckB: begin
                    state <= StIdle;
                    b_ack <= 1'b0;
                end
                default: begin
                    state <= StIdle;
                    a_ack <= 1'b0;
                    b_ack <= 1'b0;
                end
            endcase
        end
    end

    // Both ports see the same captured data; each qualifies it with its own ack.
    assign a_rdata = rdata_q;
    assign b_rdata = rdata_q;

    // Structural invariants of the arbiter.
    a_ack_one_hot: assert property (@(posedge clk) disable iff (!rst_n)
        !(a_ack && b_ack));
    single_grant: assert property (@(posedge clk) disable iff (!rst_n)
        !(grant_a && grant_b));
    ack_single_cycle: assert property (@(posedge clk) disable iff (!rst_n)
        (a_ack || b_ack) |=> !(a_ack || b_ack));
    no_write_in_ack: assert property (@(posedge clk) disable iff (!rst_n)
        (state != StIdle) |-> !mem_we);

endmodule
